// File: rtl/axi_arbiter_rr_aw.sv
// Round-robin AW arbiter for NUM_M masters with a W-route FIFO recording accepted AW order.
// Grant is registered one cycle after request and locked until handshake; a full route FIFO stalls new grants.
module axi_arbiter_rr_aw #(
  parameter int NUM_M   = 4,
  parameter int W_DEPTH = 4,
  parameter int IDX_W   = $clog2(NUM_M)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NUM_M-1:0] m_awvalid_i,
  output logic [NUM_M-1:0] m_awready_o,
  output logic             awvalid_o,
  input  logic             awready_i,
  output logic [NUM_M-1:0] aw_grnt_o,
  output logic [IDX_W-1:0] aw_idx_o,
  output logic [NUM_M-1:0] w_sel_o,
  output logic [IDX_W-1:0] w_sel_idx_o,
  output logic             w_sel_valid_o,
  input  logic             wvalid_i,
  input  logic             wready_i,
  input  logic             wlast_i,
  output logic             w_full_o
);

  localparam int PTR_W = $clog2(W_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [NUM_M-1:0] ONE_HOT0 = NUM_M'(1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [NUM_M-1:0] grnt_q, grnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] ptr_adv;
  logic [NUM_M-1:0] req_masked;
  logic [IDX_W:0]   pick_idle, pick_hs;

  logic [IDX_W-1:0] mem_q [W_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             full_nxt;
  logic             hs, pop;
  logic [IDX_W-1:0] head_idx;

  // First set bit at or above start wins; otherwise wrap to the lowest set bit.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_M-1:0] req,
                                              input logic [IDX_W-1:0] start);
    logic             hi_found, lo_found;
    logic [IDX_W-1:0] hi_idx, lo_idx;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
        if (i >= int'(start)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    if (hi_found) return {1'b1, hi_idx};
    return {lo_found, lo_idx};
  endfunction

  assign aw_grnt_o     = grnt_q;
  assign aw_idx_o      = idx_q;
  assign awvalid_o     = (|grnt_q) & m_awvalid_i[idx_q];
  assign m_awready_o   = {NUM_M{awready_i}} & grnt_q;
  assign hs            = awvalid_o & awready_i;

  assign w_sel_valid_o = (cnt_q != '0);
  assign w_full_o      = (cnt_q == CNT_W'(W_DEPTH));
  assign head_idx      = w_sel_valid_o ? mem_q[rd_ptr_q] : '0;
  assign w_sel_idx_o   = head_idx;
  assign w_sel_o       = w_sel_valid_o ? (ONE_HOT0 << head_idx) : '0;
  assign pop           = w_sel_valid_o & wvalid_i & wready_i & wlast_i;

  assign cnt_nxt       = cnt_q + CNT_W'(hs) - CNT_W'(pop);
  assign full_nxt      = (cnt_nxt == CNT_W'(W_DEPTH));

  assign ptr_adv       = (idx_q == IDX_W'(NUM_M - 1)) ? '0 : idx_q + IDX_W'(1);
  assign req_masked    = m_awvalid_i & ~grnt_q;
  assign pick_idle     = rr_pick(m_awvalid_i, ptr_q);
  assign pick_hs       = rr_pick(req_masked, ptr_adv);

  always_comb begin
    state_d = state_q;
    grnt_d  = grnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if ((|m_awvalid_i) && !w_full_o) begin
          grnt_d  = ONE_HOT0 << pick_idle[IDX_W-1:0];
          idx_d   = pick_idle[IDX_W-1:0];
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (hs) begin
          ptr_d = ptr_adv;
          // Back-to-back grant only if the route FIFO still has room after this cycle.
          if (pick_hs[IDX_W] && !full_nxt) begin
            grnt_d = ONE_HOT0 << pick_hs[IDX_W-1:0];
            idx_d  = pick_hs[IDX_W-1:0];
          end else begin
            grnt_d  = '0;
            idx_d   = '0;
            state_d = IDLE;
          end
        end else if (!m_awvalid_i[idx_q]) begin
          grnt_d  = '0;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grnt_d  = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      grnt_q   <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      grnt_q  <= grnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_nxt;
      if (hs)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage is not reset; entries are only observed while the count covers them.
  always_ff @(posedge clk_i) begin
    if (hs) mem_q[wr_ptr_q] <= idx_q;
  end

endmodule

// File: tb/tb_axi_arbiter_rr_aw.sv
// Directed bench for the round-robin AW arbiter and its W-route FIFO.
module tb_axi_arbiter_rr_aw;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] m_awready;
  logic       awvalid;
  logic       awready;
  logic [3:0] grnt;
  logic [1:0] idx;
  logic [3:0] w_sel;
  logic [1:0] w_sel_idx;
  logic       w_sel_valid;
  logic       wvalid;
  logic       wready;
  logic       wlast;
  logic       w_full;

  int checks = 0;
  int errors = 0;

  axi_arbiter_rr_aw #(.NUM_M(4), .W_DEPTH(4)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .m_awvalid_i   (req),
    .m_awready_o   (m_awready),
    .awvalid_o     (awvalid),
    .awready_i     (awready),
    .aw_grnt_o     (grnt),
    .aw_idx_o      (idx),
    .w_sel_o       (w_sel),
    .w_sel_idx_o   (w_sel_idx),
    .w_sel_valid_o (w_sel_valid),
    .wvalid_i      (wvalid),
    .wready_i      (wready),
    .wlast_i       (wlast),
    .w_full_o      (w_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input logic v);
    wvalid = v;
    wready = v;
    wlast  = v;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = '0;
    awready = 1'b0;
    set_w(1'b0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    awready = 1'b1;
    #1;
    checks++; if (grnt !== 4'b0000) begin errors++; $display("FAIL reset_grnt: got %b want 0000", grnt); end
    checks++; if (idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", idx); end
    checks++; if (w_sel_valid !== 1'b0 || w_sel !== 4'b0000) begin errors++; $display("FAIL reset_wsel: got v=%b sel=%b want v=0 sel=0000", w_sel_valid, w_sel); end
    checks++; if (w_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", w_full); end
    checks++; if (awvalid !== 1'b0 || m_awready !== 4'b0000) begin errors++; $display("FAIL reset_aw: got awvalid=%b m_awready=%b want 0/0000", awvalid, m_awready); end
  endtask

  task automatic test_reset_mid_locked();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b0110; awready = 1'b1;
    step(); step(); step();
    awready = 1'b0;
    checks++; if (grnt !== 4'b0010 || w_sel_valid !== 1'b1) begin errors++; $display("FAIL rmid_setup: got grnt=%b v=%b want 0010/1", grnt, w_sel_valid); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (grnt !== 4'b0000 || w_sel_valid !== 1'b0 || w_full !== 1'b0) begin errors++; $display("FAIL rmid_flush: got grnt=%b v=%b full=%b want 0000/0/0", grnt, w_sel_valid, w_full); end
    checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL rmid_awvalid: got %b want 0", awvalid); end
    req = 4'b1111;
    step();
    exp_g = 4'b0001;
    checks++; if (grnt !== exp_g) begin errors++; $display("FAIL rmid_ptr0: got %b want %b", grnt, exp_g); end
  endtask

  task automatic test_rr_full();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111; awready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_g = 4'b0001 << k;
      checks++; if (grnt !== exp_g || idx !== 2'(k)) begin errors++; $display("FAIL rr_grant%0d: got grnt=%b idx=%0d want %b/%0d", k, grnt, idx, exp_g, k); end
    end
    step();
    checks++; if (grnt !== 4'b0000 || w_full !== 1'b1) begin errors++; $display("FAIL rr_full: got grnt=%b full=%b want 0000/1", grnt, w_full); end
    step();
    checks++; if (grnt !== 4'b0000) begin errors++; $display("FAIL rr_no5th: got %b want 0000", grnt); end
    req = '0; awready = 1'b0;
    set_w(1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (w_sel_idx !== 2'(k) || w_sel_valid !== 1'b1) begin errors++; $display("FAIL rr_fifo%0d: got idx=%0d v=%b want %0d/1", k, w_sel_idx, w_sel_valid, k); end
      step();
    end
    set_w(1'b0);
    checks++; if (w_sel_valid !== 1'b0 || w_full !== 1'b0) begin errors++; $display("FAIL rr_drained: got v=%b full=%b want 0/0", w_sel_valid, w_full); end
  endtask

  task automatic test_lock();
    do_reset();
    req = 4'b0101; awready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (grnt !== 4'b0001 || awvalid !== 1'b1 || m_awready !== 4'b0000) begin errors++; $display("FAIL lock_hold%0d: got grnt=%b awvalid=%b m_awready=%b want 0001/1/0000", k, grnt, awvalid, m_awready); end
    end
    awready = 1'b1;
    #1;
    checks++; if (m_awready !== 4'b0001) begin errors++; $display("FAIL lock_awready: got %b want 0001", m_awready); end
    step();
    checks++; if (grnt !== 4'b0100 || idx !== 2'd2) begin errors++; $display("FAIL lock_next: got grnt=%b idx=%0d want 0100/2", grnt, idx); end
    req = '0; awready = 1'b0;
    step();
  endtask

  task automatic test_wroute();
    do_reset();
    req = 4'b1010; awready = 1'b1;
    step();
    step();
    req = 4'b1000;
    step();
    req = '0; awready = 1'b0;
    checks++; if (w_sel_idx !== 2'd1 || w_sel !== 4'b0010) begin errors++; $display("FAIL wr_head: got idx=%0d sel=%b want 1/0010", w_sel_idx, w_sel); end
    for (int b = 1; b <= 4; b++) begin
      wvalid = 1'b1; wready = 1'b1; wlast = (b == 4);
      #1;
      checks++; if (w_sel_idx !== 2'd1) begin errors++; $display("FAIL wr_beat%0d: got idx=%0d want 1", b, w_sel_idx); end
      step();
    end
    set_w(1'b0);
    checks++; if (w_sel_idx !== 2'd3 || w_sel !== 4'b1000) begin errors++; $display("FAIL wr_after_pop: got idx=%0d sel=%b want 3/1000", w_sel_idx, w_sel); end
    req = 4'b0101; awready = 1'b1;
    step();
    step();
    checks++; if (grnt !== 4'b0100 || w_sel_idx !== 2'd3) begin errors++; $display("FAIL wr_b2b: got grnt=%b head=%0d want 0100/3", grnt, w_sel_idx); end
    req = 4'b0100;
    set_w(1'b1);
    step();
    req = '0; awready = 1'b0;
    checks++; if (w_sel_idx !== 2'd0 || w_sel_valid !== 1'b1 || w_full !== 1'b0) begin errors++; $display("FAIL wr_hs_pop: got head=%0d v=%b full=%b want 0/1/0", w_sel_idx, w_sel_valid, w_full); end
    step();
    checks++; if (w_sel_idx !== 2'd2 || w_sel_valid !== 1'b1) begin errors++; $display("FAIL wr_cnt2: got head=%0d v=%b want 2/1", w_sel_idx, w_sel_valid); end
    step();
    set_w(1'b0);
    checks++; if (w_sel_valid !== 1'b0) begin errors++; $display("FAIL wr_empty: got v=%b want 0", w_sel_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0010; awready = 1'b1;
    step();
    checks++; if (grnt !== 4'b0010) begin errors++; $display("FAIL b2b_first: got %b want 0010", grnt); end
    step();
    checks++; if (grnt !== 4'b0000) begin errors++; $display("FAIL b2b_masked: got %b want 0000", grnt); end
    step();
    checks++; if (grnt !== 4'b0010) begin errors++; $display("FAIL b2b_regrant: got %b want 0010", grnt); end
    req = '0;
    step();
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b1010; awready = 1'b1;
    step();
    step();
    req = '0; awready = 1'b0;
    checks++; if (grnt !== 4'b1000 || idx !== 2'd3) begin errors++; $display("FAIL drop_granted: got grnt=%b idx=%0d want 1000/3", grnt, idx); end
    step();
    checks++; if (grnt !== 4'b0000 || idx !== 2'd0) begin errors++; $display("FAIL drop_idle: got grnt=%b idx=%0d want 0000/0", grnt, idx); end
    set_w(1'b1);
    step();
    set_w(1'b0);
    checks++; if (w_sel_valid !== 1'b0) begin errors++; $display("FAIL drop_nopush: got v=%b want 0", w_sel_valid); end
    req = 4'b1011;
    step();
    checks++; if (grnt !== 4'b1000) begin errors++; $display("FAIL drop_ptr: got %b want 1000", grnt); end
    req = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_reset_mid_locked();
    test_rr_full();
    test_lock();
    test_wroute();
    test_back_to_back();
    test_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
